// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with internal pointers, occupancy count and threshold flags.
// Define FIFO_ERR_EN to build the sticky overflow/underflow error flags; otherwise they read 0.
module fifo_sync_param #(
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned AF_MARGIN  = 2,
   parameter int unsigned AE_MARGIN  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] fifo_Data_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] fifo_Data_out,
   output logic                  valid_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   fifo_count,
   output logic                  overflow_err,
   output logic                  underflow_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FullCnt = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AfCnt   = (ADDR_WIDTH + 1)'(DEPTH - AF_MARGIN);
   localparam logic [ADDR_WIDTH:0] AeCnt   = (ADDR_WIDTH + 1)'(AE_MARGIN);
   localparam logic [ADDR_WIDTH:0] One     = (ADDR_WIDTH + 1)'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  valid_q;
   logic                  wr_en, rd_en;

   // Flags decode only from the registered count, never from push/pop.
   assign full         = (count_q == FullCnt);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AfCnt);
   assign almost_empty = (count_q <= AeCnt);
   assign fifo_count   = count_q;
   assign fifo_Data_out = dout_q;
   assign valid_out    = valid_q;

   // A pop on a full FIFO frees a slot in the same cycle; no bypass when empty.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + One;
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + One;
         dout_d   = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
      if (wr_en && !rd_en) count_d = count_q + One;
      else if (rd_en && !wr_en) count_d = count_q - One;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         valid_q  <= rd_en;
      end
   end

   // Storage is not reset.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= fifo_Data_in;
   end

`ifdef FIFO_ERR_EN
   logic ovf_q, unf_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (push && full && !pop) ovf_q <= 1'b1;
         if (pop && empty) unf_q <= 1'b1;
      end
   end

   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;
`else
   assign overflow_err  = 1'b0;
   assign underflow_err = 1'b0;
`endif

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock synchronous FIFO with integrated storage, read/write pointer management, occupancy count, programmable almost-full/almost-empty flags and overflow/underflow detection. It replaces externally driven read/write addressing of the 10-bit × 8 memory with internal pointer control, so producers and consumers only drive push/pop. It sits between a packet source and its consumer in the datapath.

## Interface
- DATA_WIDTH, 10, word width in bits
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (8)
- AF_MARGIN, 2, almost_full asserts when count >= DEPTH - AF_MARGIN
- AE_MARGIN, 2, almost_empty asserts when count <= AE_MARGIN

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- push  in  1  write request
- fifo_Data_in  in  DATA_WIDTH  write data, sampled with push
- pop  in  1  read request
- fifo_Data_out  out  DATA_WIDTH  registered read data
- valid_out  out  1  one-cycle pulse: fifo_Data_out updated by an accepted pop
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  threshold flag per AF_MARGIN
- almost_empty  out  1  threshold flag per AE_MARGIN
- fifo_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow_err  out  1  sticky: push attempted while full and not popping
- underflow_err  out  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH × DATA_WIDTH register array; write pointer wr_ptr and read pointer rd_ptr, each ADDR_WIDTH+1 bits (extra wrap bit); index = low ADDR_WIDTH bits.
- Accepted write: push && (!full || pop). Stores fifo_Data_in at wr_ptr, wr_ptr += 1 (modulo 2**(ADDR_WIDTH+1)).
- Accepted read: pop && !empty. fifo_Data_out <= mem[rd_ptr], rd_ptr += 1, valid_out = 1 next cycle.
- Rejected push (full, no pop): memory and wr_ptr unchanged; overflow_err set.
- Rejected pop (empty): rd_ptr and fifo_Data_out unchanged, valid_out 0; underflow_err set.
- Push+pop when empty: write accepted, pop rejected (no bypass), count 0→1, underflow_err set.
- Push+pop when full: both accepted, count stays DEPTH, oldest word read out, no overflow.
- Push+pop otherwise: both accepted, count unchanged.
- fifo_count: +1 on write only, −1 on read only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
- full/empty/almost flags decoded from registered fifo_count; no combinational path from push/pop.
- fifo_Data_out holds last read value when no read accepted.
- Error flags clear only on reset.

## Timing
- Reset values: fifo_Data_out 0, valid_out 0, full 0, empty 1, almost_full 0, almost_empty 1, fifo_count 0, overflow_err 0, underflow_err 0, both pointers 0. Memory contents not reset.
- Reset asserted mid-operation: all above take reset values immediately (asynchronous); in-flight push/pop that edge discarded.
- Write-to-read latency: word pushed at edge N is poppable at edge N+1 (empty deasserts after edge N); data visible on fifo_Data_out after the pop edge, with valid_out high that cycle.
- Read latency: one cycle from sampled pop to fifo_Data_out/valid_out.
- Flags and fifo_count update on the same edge as the accepted operation.
- Pointer wrap: after DEPTH writes wr_ptr index returns to 0 with wrap bit toggled; full iff indices equal and wrap bits differ.

## Configuration
- FIFO_ERR_EN defined: overflow_err/underflow_err implemented as sticky flags per Operation.
- FIFO_ERR_EN undefined: error logic removed, both ports tied 0; rejection behaviour of push/pop unchanged.

## Test plan
- Reset: assert reset mid-sequence after 3 pushes -> fifo_count 0, empty 1, almost_empty 1, fifo_Data_out 0 asynchronously.
- Fill/drain: push 0x091, 0x04A, 0x093 then pop ×3 -> fifo_Data_out 0x091, 0x04A, 0x093 on consecutive cycles, valid_out high each, empty 1 after third pop.
- Full and overflow: 8 pushes (values 1..8) -> full 1, almost_full 1 from count 6; 9th push -> count stays 8, overflow_err 1; 8 pops return 1..8.
- Underflow/simultaneous-empty: pop on empty -> underflow_err 1, valid_out 0; push 0x165 with pop on empty -> count 1, next pop returns 0x165.
- Full simultaneous: at count 8 push 0x3FF with pop -> returns oldest word, count 8, overflow_err 0; after 8 more pops last value 0x3FF.
- Wrap-around: 20 interleaved push/pop cycles at count 3 -> data order preserved across pointer wrap, fifo_count constant at 3.
